mux81_bit_sequencer: RTL

- Upstream controller for the 8:1 bit-select mux. Accepts a byte over a valid/ready handshake and holds it on the mux word input.
- Steps the mux select through all eight positions, holding each for a programmable number of clocks, and reads back the mux output bit.
- Presents the mux output as a framed serial bit stream for the next stage.
- Sits between a byte producer and the serial consumer, with the mux instantiated alongside it.

---
 rtl/mux81_seq_if.sv | 19 +
 rtl/mux81_bit_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mux81_seq_if.sv
// Byte load handshake between the producer and the 8:1 mux bit sequencer.
// The producer drives the master side; the sequencer takes the slave side.
interface mux81_seq_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/mux81_bit_sequencer.sv
// Drives an external 8:1 bit-select mux through all eight selects and frames its output as a serial stream.
// Optional even-parity trailer bit is enabled by defining MUX81_SEQ_PARITY_EN.
module mux81_bit_sequencer #(
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  mux81_seq_if.slave  load,
  output logic [7:0]  mux_word,
  output logic [2:0]  mux_sel,
  input  logic        mux_bit,
  output logic        ser_out,
  output logic        ser_valid,
  output logic        frame_done,
  output logic        busy
);

  if (CLK_DIV < 1) begin : g_div_check
    $error("mux81_bit_sequencer: CLK_DIV must be at least 1");
  end

  localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]      SEL_FIRST = (MSB_FIRST != 0) ? 3'd7 : 3'd0;

`ifdef MUX81_SEQ_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic             div_last;
  logic             xfer;
  logic             ready;

  assign div_last        = (div_cnt == DIV_LAST);
  assign load.load_ready = ready;

`ifdef MUX81_SEQ_PARITY_EN
  logic par_acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    xfer       = 1'b0;
    ready      = 1'b0;
    ser_valid  = 1'b0;
    ser_out    = 1'b1;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy  = 1'b0;
        ready = 1'b1;
        if (load.load_valid) begin
          xfer       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = mux_bit;
        if (div_last && (bit_cnt == 3'd7)) begin
`ifdef MUX81_SEQ_PARITY_EN
          state_next = PARITY;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef MUX81_SEQ_PARITY_EN
      PARITY: begin
        ser_valid = 1'b1;
        ser_out   = par_acc;
        if (div_last) begin
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Select and counters only move on a transfer or while a bit is being held;
  // mux_sel therefore parks on its last position until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_word <= 8'd0;
      mux_sel  <= 3'd0;
      div_cnt  <= '0;
      bit_cnt  <= 3'd0;
    end else if (xfer) begin
      mux_word <= load.load_data;
      mux_sel  <= SEL_FIRST;
      div_cnt  <= '0;
      bit_cnt  <= 3'd0;
    end else if (state == SHIFT) begin
      if (div_last) begin
        div_cnt <= '0;
        if (bit_cnt != 3'd7) begin
          bit_cnt <= bit_cnt + 3'd1;
          mux_sel <= (MSB_FIRST != 0) ? (mux_sel - 3'd1) : (mux_sel + 3'd1);
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
`ifdef MUX81_SEQ_PARITY_EN
    end else if (state == PARITY) begin
      div_cnt <= div_last ? '0 : (div_cnt + DIV_W'(1));
`endif
    end
  end

`ifdef MUX81_SEQ_PARITY_EN
  // Each bit is sampled once, on the final cycle it is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
    end else if (xfer) begin
      par_acc <= 1'b0;
    end else if ((state == SHIFT) && div_last) begin
      par_acc <= par_acc ^ mux_bit;
    end
  end
`endif

endmodule
